// File: rtl/calc_alu_seq.sv
// Multi-cycle signed ALU: add/sub in 1 cycle, mul/div/rem iterate one bit per cycle; define ALU_OVF_EN for al_ovf.
// Latency: add/sub/illegal done in cycle 1, mul/div/rem in WIDTH+2 (div-by-zero 2); al_start is ignored unless idle.
module calc_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             al_start,
  input  logic [WIDTH-1:0] al_A,
  input  logic [WIDTH-1:0] al_B,
  input  logic [CMD_W-1:0] al_cmd,
  output logic [WIDTH-1:0] al_C,
  output logic             al_busy,
  output logic             al_done,
  output logic             al_err,
  output logic             al_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CMD_W-1:0] CMD_AD = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_SB = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_ML = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_DV = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_RM = CMD_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [CMD_W-1:0]   cmd_r;
  logic [WIDTH-1:0]   a_r, b_r, mb_r, q_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r;

  logic [WIDTH-1:0]   sum_ab, dif_ab, mag_a, mag_b;
  logic [WIDTH-1:0]   q_in, mb_in, q_nxt, res_lo, res_dv;
  logic [2*WIDTH-1:0] acc_in, acc_nxt;
  logic [WIDTH:0]     rem_try;

  assign sum_ab = al_A + al_B;
  assign dif_ab = al_A - al_B;
  assign mag_a  = a_r[WIDTH-1] ? -a_r : a_r;
  assign mag_b  = b_r[WIDTH-1] ? -b_r : b_r;

  // LOAD already performs the first (MSB) step straight from the operand magnitudes.
  assign acc_in = (state == S_LOAD) ? '0 : acc_r;
  assign q_in   = (state == S_LOAD) ? mag_a : q_r;
  assign mb_in  = (state == S_LOAD) ? mag_b : mb_r;

  always_comb begin
    acc_nxt = '0;
    q_nxt   = {q_in[WIDTH-2:0], 1'b0};
    rem_try = '0;
    if (cmd_r == CMD_ML) begin
      acc_nxt = {acc_in[2*WIDTH-2:0], 1'b0} + (q_in[WIDTH-1] ? {{WIDTH{1'b0}}, mb_in} : '0);
    end else begin
      rem_try = {acc_in[WIDTH-1:0], q_in[WIDTH-1]};
      if (rem_try >= {1'b0, mb_in}) begin
        rem_try  = rem_try - {1'b0, mb_in};
        q_nxt[0] = 1'b1;
      end
      acc_nxt = {{WIDTH{1'b0}}, rem_try[WIDTH-1:0]};
    end
  end

  // Low half of the accumulator holds the product (mul) or remainder (rem) magnitude.
  assign res_lo = neg_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
  assign res_dv = neg_r ? -q_r : q_r;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      cmd_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      mb_r    <= '0;
      q_r     <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      neg_r   <= 1'b0;
      al_C    <= '0;
      al_busy <= 1'b0;
      al_done <= 1'b0;
      al_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (al_start) begin
            cmd_r  <= al_cmd;
            a_r    <= al_A;
            b_r    <= al_B;
            al_err <= 1'b0;
            case (al_cmd)
              CMD_AD: begin
                al_C    <= sum_ab;
                al_done <= 1'b1;
                state   <= S_DONE;
              end
              CMD_SB: begin
                al_C    <= dif_ab;
                al_done <= 1'b1;
                state   <= S_DONE;
              end
              CMD_ML, CMD_DV, CMD_RM: begin
                al_busy <= 1'b1;
                state   <= S_LOAD;
              end
              default: begin
                al_C    <= '0;
                al_err  <= 1'b1;
                al_done <= 1'b1;
                state   <= S_DONE;
              end
            endcase
          end
        end
        S_LOAD: begin
          neg_r <= (cmd_r == CMD_RM) ? a_r[WIDTH-1] : (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          mb_r  <= mag_b;
          if (cmd_r != CMD_ML && b_r == '0) begin
            al_C    <= '0;
            al_err  <= 1'b1;
            al_done <= 1'b1;
            al_busy <= 1'b0;
            state   <= S_DONE;
          end else begin
            acc_r <= acc_nxt;
            q_r   <= q_nxt;
            cnt_r <= CNT_W'(WIDTH - 1);
            state <= S_ITER;
          end
        end
        S_ITER: begin
          acc_r <= acc_nxt;
          q_r   <= q_nxt;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          al_C    <= (cmd_r == CMD_DV) ? res_dv : res_lo;
          al_busy <= 1'b0;
          al_done <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          al_done <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_OVF_EN
  logic               add_ovf, sub_ovf, mul_ovf, div_ovf;
  logic [2*WIDTH-1:0] half_rng;

  assign half_rng = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  assign add_ovf  = (al_A[WIDTH-1] == al_B[WIDTH-1]) && (sum_ab[WIDTH-1] != al_A[WIDTH-1]);
  assign sub_ovf  = (al_A[WIDTH-1] != al_B[WIDTH-1]) && (dif_ab[WIDTH-1] != al_A[WIDTH-1]);
  // A negative product may reach magnitude 2^(WIDTH-1); a positive one may not.
  assign mul_ovf  = neg_r ? (acc_r > half_rng) : (acc_r >= half_rng);
  assign div_ovf  = !neg_r && q_r[WIDTH-1];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      al_ovf <= 1'b0;
    end else if (state == S_IDLE && al_start) begin
      al_ovf <= ((al_cmd == CMD_AD) && add_ovf) || ((al_cmd == CMD_SB) && sub_ovf);
    end else if (state == S_FIX) begin
      al_ovf <= ((cmd_r == CMD_ML) && mul_ovf) || ((cmd_r == CMD_DV) && div_ovf);
    end
  end
`else
  assign al_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_calc_alu_seq.sv
// Randomized scoreboard bench for calc_alu_seq against a 64-bit arithmetic reference model.
module tb_calc_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        al_start = 1'b0;
  logic [31:0] al_A = '0, al_B = '0;
  logic [2:0]  al_cmd = '0;
  logic [31:0] al_C;
  logic        al_busy, al_done, al_err, al_ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] a, b, c;
    logic        err, ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  calc_alu_seq #(.WIDTH(32), .CMD_W(3)) dut (
    .Clock(clk), .Reset(rst), .al_start(al_start), .al_A(al_A), .al_B(al_B),
    .al_cmd(al_cmd), .al_C(al_C), .al_busy(al_busy), .al_done(al_done),
    .al_err(al_err), .al_ovf(al_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit values, then wrap to 32 bits.
  function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, r;
    logic   ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    e.cmd = cmd; e.a = a; e.b = b; e.err = 1'b0; e.lat = 34; e.acc = 0;
    case (cmd)
      3'd0: begin r = sa + sb; e.lat = 1; end
      3'd1: begin r = sa - sb; e.lat = 1; end
      3'd2: r = sa * sb;
      3'd3: if (sb == 0) begin e.err = 1'b1; e.lat = 2; end else r = sa / sb;
      3'd4: if (sb == 0) begin e.err = 1'b1; e.lat = 2; end else r = sa % sb;
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.c = r[31:0];
    ovf = (cmd <= 3'd3) && (r > 64'sd2147483647 || r < -64'sd2147483648);
`ifdef ALU_OVF_EN
    e.ovf = ovf;
`else
    e.ovf = 1'b0 & ovf;
`endif
    return e;
  endfunction

  // Monitor: busy window and result checks against the head of the scoreboard.
  always @(negedge clk) begin
    int   rel;
    logic exp_busy;
    exp_t e;
    if (!rst) begin
      exp_busy = 1'b0;
      rel = 0;
      if (sbq.size() > 0) begin
        rel = cyc - sbq[0].acc + 1;
        exp_busy = (rel >= 1) && (rel <= sbq[0].lat - 1);
      end
      chk("busy", {31'd0, al_busy}, {31'd0, exp_busy});
      if (al_done) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got al_done=1 with al_C=%h, required no done (cycle %0d)", al_C, cyc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("latency cmd=%0d", e.cmd), rel, e.lat);
          chk($sformatf("result cmd=%0d a=%h b=%h", e.cmd, e.a, e.b), al_C, e.c);
          chk($sformatf("err cmd=%0d", e.cmd), {31'd0, al_err}, {31'd0, e.err});
          chk($sformatf("ovf cmd=%0d a=%h b=%h", e.cmd, e.a, e.b), {31'd0, al_ovf}, {31'd0, e.ovf});
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no al_done within 100 cycles, required one");
      sbq.delete();
    end
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    al_cmd = cmd; al_A = a; al_B = b; al_start = 1'b1;
    e = model(cmd, a, b);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    al_start = 1'b0;
    al_A = $urandom; al_B = $urandom; al_cmd = 3'($urandom);
  endtask

  task automatic do_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    issue(cmd, a, b);
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 40)) - 32'd20;
      2: return sp[$urandom_range(0, 4)];
      default: return 32'($urandom_range(0, 70000)) - 32'd35000;
    endcase
  endfunction

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("reset al_C", al_C, 32'd0);
    chk("reset al_busy", {31'd0, al_busy}, 32'd0);
    chk("reset al_done", {31'd0, al_done}, 32'd0);
    chk("reset al_err", {31'd0, al_err}, 32'd0);
    chk("reset al_ovf", {31'd0, al_ovf}, 32'd0);
    rst = 1'b0;

    do_op(3'd0, 32'd5, -32'd9);
    do_op(3'd4, 32'd123, 32'd10);
    do_op(3'd3, 32'd123, 32'd10);
    do_op(3'd3, -32'd7, 32'd2);
    do_op(3'd4, -32'd7, 32'd2);
    do_op(3'd2, -32'd6, 32'd7);
    do_op(3'd3, 32'd100, 32'd0);
    do_op(3'd0, 32'd1, 32'd1);
    do_op(3'd4, 32'd5, 32'd0);
    do_op(3'd1, 32'h8000_0000, 32'd1);
    do_op(3'd5, 32'd3, 32'd4);
    do_op(3'd7, 32'd3, 32'd4);
    do_op(3'd0, 32'h7FFF_FFFF, 32'd1);
    do_op(3'd2, 32'h0001_0000, 32'h0001_0000);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_0000, 32'h0000_8000);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd3, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
    end

    // A start pulse mid-iteration must be dropped, not queued.
    issue(3'd3, 32'd1000, 32'd10);
    repeat (5) @(negedge clk);
    al_cmd = 3'd0; al_A = 32'd1; al_B = 32'd1; al_start = 1'b1;
    @(negedge clk);
    al_start = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);

    // Reset in cycle 10 of a multiply kills it with no done pulse.
    issue(3'd2, -32'd6, 32'd7);
    acc = sbq[0].acc;
    while (cyc - acc + 1 < 10) @(negedge clk);
    #2 rst = 1'b1;
    sbq.delete();
    #1;
    chk("midop reset al_C", al_C, 32'd0);
    chk("midop reset al_busy", {31'd0, al_busy}, 32'd0);
    chk("midop reset al_done", {31'd0, al_done}, 32'd0);
    chk("midop reset al_err", {31'd0, al_err}, 32'd0);
    chk("midop reset al_ovf", {31'd0, al_ovf}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(3'd0, 32'd2, 32'd3);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Multi-cycle integer ALU directly downstream of the controller's ALU operand mux. It consumes al_A, al_B and al_cmd, and returns al_C to the controller. Add and subtract finish in one cycle. Multiply, divide and remainder are iterative (one bit per cycle). A start/busy/done handshake lets the controller state machine wait on long operations such as the digit-extraction remainder by 10.

Parameters:
WIDTH, 32, operand/result width in bits, two's complement (matches CD_N)
CMD_W, 3, command field width (matches AC_N)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
al_start  input  1  request; sampled only in IDLE
al_A  input  WIDTH  operand A, signed
al_B  input  WIDTH  operand B, signed
al_cmd  input  CMD_W  0=AD add, 1=SB sub, 2=ML mul, 3=DV div, 4=RM rem, 5-7 illegal
al_C  output  WIDTH  result, held until next accepted start
al_busy  output  1  high from the cycle after accept until done
al_done  output  1  one-cycle pulse, result valid
al_err  output  1  divide-by-zero or illegal command; valid with al_done, held until next start
al_ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE; al_C=0, al_busy=0, al_done=0, al_err=0, al_ovf=0. Any in-flight operation is discarded, and no done pulse is issued for it.
- Operands and command are captured on the accepting edge. Later changes to the inputs have no effect.
- FSM states: IDLE, LOAD, ITER, FIX, DONE.
- IDLE:
  - al_start=1 with AD/SB/illegal -> DONE.
  - al_start=1 with ML/DV/RM -> LOAD.
- LOAD:
  - Takes the magnitudes of A and B and records the result sign.
  - ML: sign = sA^sB.
  - DV: quotient sign = sA^sB.
  - RM: sign = sA.
  - DV/RM with B=0 -> DONE with al_err=1 and al_C=0.
  - Otherwise -> ITER, with the counter set to WIDTH-1.
- ITER:
  - One step per cycle.
  - ML: shift-add.
  - DV/RM: restoring shift-subtract.
  - Counter decrements; at 0 -> FIX.
- FIX: applies the sign to the magnitude result; ML keeps the low WIDTH bits -> DONE.
- DONE:
  - Drives al_C/al_err/al_ovf and pulses al_done for one cycle -> IDLE.
  - AD/SB: al_C = A±B mod 2^WIDTH.
  - Illegal: al_C=0, al_err=1.
- Latency, with the accepting edge as cycle 0:
  - AD/SB/illegal: al_done in cycle 1.
  - ML/DV/RM: al_done in cycle WIDTH+2. Divide-by-zero: cycle 2.
- al_busy is high in LOAD/ITER/FIX and low in IDLE/DONE.
- al_start outside IDLE (including the DONE cycle) is ignored and never queued.
- Division truncates toward zero. The remainder takes the dividend's sign, so A = q*B + r always holds.
- MIN DV -1 produces MIN (wraps). MIN RM -1 produces 0.

Optional Feature:
ALU_OVF_EN
- Defined: al_ovf is set with al_done when any of these occur:
  - AD/SB signed overflow.
  - ML product not representable in WIDTH signed bits.
  - DV of MIN by -1.
  Cleared on the next accepted start.
- Not defined: al_ovf is tied to 0 and no overflow logic is synthesised.
- al_C values are identical in both builds.

Test Plan:
- WIDTH=32. Accept AD with A=5, B=-9 -> cycle 1: al_done=1, al_C=-4, al_err=0, al_busy never high.
- Accept RM with A=123, B=10 -> al_busy high cycles 1-33, al_done in cycle 34, al_C=3. Repeat with DV -> al_C=12.
- DV with A=-7, B=2 -> al_C=-3. RM with A=-7, B=2 -> al_C=-1. ML with A=-6, B=7 -> al_C=-42 in cycle 34.
- DV with A=100, B=0 -> al_done in cycle 2, al_err=1, al_C=0. Next AD 1+1 -> al_C=2 and al_err cleared.
- Pulse al_start during ITER of a DV 1000/10 -> ignored; exactly one al_done, al_C=100. Assert Reset in cycle 10 of a ML -> all outputs 0 immediately; no al_done; next AD accepted normally.
- With ALU_OVF_EN: AD 0x7FFFFFFF+1 -> al_C=0x80000000, al_ovf=1. ML 0x10000*0x10000 -> al_C=0, al_ovf=1. Without the macro -> same al_C, al_ovf=0.
